boxcar_decimator: RTL and testbench



---
 rtl/boxcar_decimator_pkg.sv | 18 +
 rtl/boxcar_decimator_if.sv | 23 ++
 rtl/boxcar_decimator.sv | 96 +++++++++
 tb/tb_boxcar_decimator.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/boxcar_decimator_pkg.sv
// Shared DSP helpers for the boxcar decimator: accumulator sizing,
// FILL/DUMP state type and the DecimationLog2 legality check.
package boxcar_decimator_pkg;

    typedef enum logic {
        FILL = 1'b0,
        DUMP = 1'b1
    } state_e;

    function automatic int acc_width(int word_bits, int dec_log2);
        return word_bits + dec_log2;
    endfunction

    function automatic bit dec_log2_ok(int dec_log2);
        return (dec_log2 >= 1) && (dec_log2 <= 8);
    endfunction

endpackage

// File: rtl/boxcar_decimator_if.sv
// Sample stream into and decimated stream out of the boxcar decimator,
// both valid/ready, plus the partial-block flush strobe.
interface boxcar_decimator_if #(
    parameter int WordLengthBits = 12
);
    logic signed [WordLengthBits-1:0] in_data;
    logic                             in_valid;
    logic                             in_ready;
    logic                             flush;
    logic signed [WordLengthBits-1:0] out_data;
    logic                             out_valid;
    logic                             out_ready;

    modport master (
        output in_data, in_valid, flush, out_ready,
        input  in_ready, out_data, out_valid
    );

    modport slave (
        input  in_data, in_valid, flush, out_ready,
        output in_ready, out_data, out_valid
    );
endinterface

// File: rtl/boxcar_decimator.sv
// Integrate-and-dump decimator: emits the mean of each 2**DecimationLog2
// accepted samples. Define ROUNDING_EN for round-half-up instead of floor.
module boxcar_decimator
    import boxcar_decimator_pkg::*;
#(
    parameter int WordLengthBits = 12,
    parameter int DecimationLog2 = 2
) (
    input logic               clk,
    input logic               rst,
    boxcar_decimator_if.slave bus
);
    localparam int W    = WordLengthBits;
    localparam int D    = DecimationLog2;
    localparam int AccW = acc_width(W, D);

    localparam logic [D-1:0] LastCnt = '1;
`ifdef ROUNDING_EN
    localparam logic signed [AccW-1:0] RoundTerm = AccW'(2 ** (D - 1));
`else
    localparam logic signed [AccW-1:0] RoundTerm = '0;
`endif

    if (!dec_log2_ok(D)) begin : g_bad_cfg
        $error("boxcar_decimator: DecimationLog2 must be 1..8");
    end

    state_e                  state_q, state_d;
    logic [D-1:0]            cnt_q, cnt_d;
    logic signed [AccW-1:0]  sum_q, sum_d;
    logic signed [W-1:0]     out_q, out_d;
    logic                    ov_q, ov_d;

    logic                    accept;
    logic signed [AccW-1:0]  in_ext;
    logic signed [AccW-1:0]  total;
    logic signed [W-1:0]     result;

    assign bus.in_ready  = !ov_q || bus.out_ready;
    assign bus.out_data  = out_q;
    assign bus.out_valid = ov_q;

    assign accept = bus.in_valid && bus.in_ready;
    assign in_ext = {{D{bus.in_data[W-1]}}, bus.in_data};
    assign total  = sum_q + in_ext + RoundTerm;
    // The block mean always fits W bits, so truncation never wraps.
    assign result = W'(total >>> D);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        out_d   = out_q;
        ov_d    = ov_q;
        if (ov_q && bus.out_ready) begin
            ov_d = 1'b0;
        end
        if (bus.flush) begin
            state_d = FILL;
            cnt_d   = '0;
            sum_d   = '0;
        end else if (accept) begin
            unique case (state_q)
                FILL: begin
                    sum_d   = sum_q + in_ext;
                    cnt_d   = cnt_q + 1'b1;
                    state_d = (cnt_d == LastCnt) ? DUMP : FILL;
                end
                DUMP: begin
                    out_d   = result;
                    ov_d    = 1'b1;
                    sum_d   = '0;
                    cnt_d   = '0;
                    state_d = FILL;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FILL;
            cnt_q   <= '0;
            sum_q   <= '0;
            out_q   <= '0;
            ov_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            out_q   <= out_d;
            ov_q    <= ov_d;
        end
    end

endmodule

// File: tb/tb_boxcar_decimator.sv
// Directed bench for boxcar_decimator (N=4, W=12) with an expected-output
// queue filled from a behavioural block-mean model.
module tb_boxcar_decimator;

    logic clk;
    logic rst;

    boxcar_decimator_if #(.WordLengthBits(12)) bus ();

    boxcar_decimator #(
        .WordLengthBits(12),
        .DecimationLog2(2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_asrt = 0;
    int n_fail = 0;
    int q[$];
    int buf_sum = 0;
    int buf_n = 0;
    bit mov = 1'b0;

    function automatic int mean4(int s);
`ifdef ROUNDING_EN
        return (s + 2) >>> 2;
`else
        return s >>> 2;
`endif
    endfunction

    task automatic chk(string tag, logic signed [31:0] obs,
                       logic signed [31:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(int v, bit vld, bit fl, bit ordy);
        bit rdy;
        bit acc;
        bit load;
        int e;
        logic signed [31:0] o;
        bus.in_data   = 12'(v);
        bus.in_valid  = vld;
        bus.flush     = fl;
        bus.out_ready = ordy;
        #1;
        rdy = !mov || ordy;
        chk("in_ready", {31'b0, bus.in_ready}, {31'b0, rdy});
        chk("out_valid", {31'b0, bus.out_valid}, {31'b0, mov});
        if (mov && ordy) begin
            e = (q.size() > 0) ? q.pop_front() : 99999;
            o = bus.out_data;
            chk("out", o, e);
        end
        acc  = vld && rdy;
        load = 1'b0;
        if (fl) begin
            buf_sum = 0;
            buf_n   = 0;
        end else if (acc) begin
            buf_sum += v;
            buf_n++;
            if (buf_n == 4) begin
                q.push_back(mean4(buf_sum));
                buf_sum = 0;
                buf_n   = 0;
                load    = 1'b1;
            end
        end
        if (load) mov = 1'b1;
        else if (ordy) mov = 1'b0;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic block4(int a, int b, int c, int d, bit ordy);
        step(a, 1'b1, 1'b0, ordy);
        step(b, 1'b1, 1'b0, ordy);
        step(c, 1'b1, 1'b0, ordy);
        step(d, 1'b1, 1'b0, ordy);
    endtask

    task automatic chk_reset_outputs(string tag);
        logic signed [31:0] o;
        o = bus.out_data;
        chk({tag, "_out"}, o, 0);
        chk({tag, "_out_valid"}, {31'b0, bus.out_valid}, 0);
        chk({tag, "_in_ready"}, {31'b0, bus.in_ready}, 1);
    endtask

    initial begin
        rst           = 1'b1;
        bus.in_data   = '0;
        bus.in_valid  = 1'b0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b0;

        // basic means, positive, negative and full-scale
        block4(1, 2, 3, 4, 1'b1);
        step(0, 1'b0, 1'b0, 1'b1);
        step(0, 1'b0, 1'b0, 1'b1);
        block4(-1, -2, -3, -4, 1'b1);
        step(0, 1'b0, 1'b0, 1'b1);
        block4(2047, 2047, 2047, 2047, 1'b1);
        block4(-2048, -2048, -2048, -2048, 1'b1);
        step(0, 1'b0, 1'b0, 1'b1);

        // backpressure: held result, ignored input, then release
        block4(10, 10, 10, 10, 1'b0);
        step(99, 1'b1, 1'b0, 1'b0);
        step(99, 1'b1, 1'b0, 1'b0);
        step(99, 1'b1, 1'b0, 1'b0);
        block4(4, 4, 4, 4, 1'b1);
        step(0, 1'b0, 1'b0, 1'b1);

        // flush discards partial block and the concurrent sample
        step(100, 1'b1, 1'b0, 1'b1);
        step(100, 1'b1, 1'b0, 1'b1);
        step(100, 1'b1, 1'b1, 1'b1);
        block4(8, 8, 8, 8, 1'b1);
        step(0, 1'b0, 1'b0, 1'b1);
        step(0, 1'b0, 1'b0, 1'b1);

        // asynchronous reset mid-block
        step(7, 1'b1, 1'b0, 1'b1);
        step(7, 1'b1, 1'b0, 1'b1);
        step(7, 1'b1, 1'b0, 1'b1);
        bus.in_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk_reset_outputs("async_rst");
        buf_sum = 0;
        buf_n   = 0;
        mov     = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        block4(5, 5, 5, 5, 1'b1);
        step(0, 1'b0, 1'b0, 1'b1);
        step(0, 1'b0, 1'b0, 1'b1);

        chk("drained", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_asrt, n_fail);
        $finish;
    end

endmodule
